// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, the bit positions of the
// c0_exception vector {sys,mfc0,mtc0,eret,break,ov,adel,ades,ri}, and the ExcCode
// priority encoder.
package cp0_regfile_pkg;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0a;
  localparam logic [4:0] ExcOv   = 5'h0c;

  localparam int unsigned ExcBitRi   = 0;
  localparam int unsigned ExcBitAdes = 1;
  localparam int unsigned ExcBitAdel = 2;
  localparam int unsigned ExcBitOv   = 3;
  localparam int unsigned ExcBitBrk  = 4;
  localparam int unsigned ExcBitEret = 5;
  localparam int unsigned ExcBitMtc0 = 6;
  localparam int unsigned ExcBitMfc0 = 7;
  localparam int unsigned ExcBitSys  = 8;

  // Winning ExcCode; only meaningful when at least one source is active.
  function automatic logic [4:0] exc_code(input logic intr, input logic [8:0] e);
    if (intr)                 return ExcInt;
    else if (e[ExcBitAdel])   return ExcAdel;
    else if (e[ExcBitRi])     return ExcRi;
    else if (e[ExcBitOv])     return ExcOv;
    else if (e[ExcBitSys])    return ExcSys;
    else if (e[ExcBitBrk])    return ExcBp;
    else                      return ExcAdes;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// WB <-> CP0 interface.
//   master (writeback): drives exception vector, interrupt tag, mtc0 address/data,
//                       WB slot valid/bd/pc and faulting address.
//   slave (CP0):        returns mfc0 data/valid, pipeline flush and redirect PC.
interface cp0_regfile_if;
  logic [8:0]  c0_exception;
  logic        c0_int;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        c0_wb_valid;
  logic        c0_wb_bd;
  logic [31:0] c0_wb_pc;
  logic [31:0] ws_badvaddr;
  logic        c0_valid;
  logic [31:0] c0_res;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output c0_exception, c0_int, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd, c0_wb_pc,
           ws_badvaddr,
    input  c0_valid, c0_res, flush, flush_pc
  );

  modport slave (
    input  c0_exception, c0_int, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd, c0_wb_pc,
           ws_badvaddr,
    output c0_valid, c0_res, flush, flush_pc
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 timer: Count (advances once every COUNT_DIV clocks), Compare and the sticky
// timer-interrupt flag TI.
//   clk, resetn          clock, async active-low reset
//   count_we, compare_we mtc0 write strobes
//   wdata                mtc0 data
//   count, compare       current register values
//   ti                   timer interrupt, set on Count==Compare, cleared by a Compare write
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DivW-1:0] PhaseLast = DivW'(COUNT_DIV - 1);

  logic [DivW-1:0] phase_q, phase_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     compare_q, compare_d;
  logic            ti_q, ti_d;
  logic            tick;

  always_comb begin
    tick      = (phase_q == PhaseLast);
    // The divider keeps running through a Count write.
    phase_d   = tick ? '0 : phase_q + DivW'(1);
    count_d   = count_we ? wdata : (tick ? count_q + 32'd1 : count_q);
    compare_d = compare_we ? wdata : compare_q;
    // Match uses registered values; a Compare write clears TI and beats a match.
    if (compare_we)                  ti_d = 1'b0;
    else if (count_q == compare_q)   ti_d = 1'b1;
    else                             ti_d = ti_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register block: BadVAddr, Count, Compare, Status, Cause, EPC.
//   clk, resetn  clock, async active-low reset
//   bus          WB->CP0 interface (slave side): exception/mtc0/eret in, mfc0/flush out
//   ext_int      level-sensitive hardware interrupt lines
//   c0_has_int   unmasked interrupt pending, used by decode to tag instructions
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic          clk,
  input  logic          resetn,
  cp0_regfile_if.slave  bus,
  input  logic [5:0]    ext_int,
  output logic          c0_has_int
);

  logic [8:0]  e;
  logic        v, exc, ert, wr;
  logic [4:0]  code;
  logic        count_we, compare_we, ti;
  logic [31:0] count, compare;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] status_rd, cause_rd;

  assign e = bus.c0_exception;

  always_comb begin
    v    = bus.c0_wb_valid;
    exc  = v & (bus.c0_int | e[ExcBitSys] | e[ExcBitBrk] | e[ExcBitOv] | e[ExcBitAdel] |
                e[ExcBitAdes] | e[ExcBitRi]);
    ert  = v & e[ExcBitEret] & ~exc;
    wr   = v & e[ExcBitMtc0] & ~exc;
    code = exc_code(bus.c0_int, e);
  end

  assign count_we   = wr & (bus.c0_addr == RegCount);
  assign compare_we = wr & (bus.c0_addr == RegCompare);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (bus.c0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};
    if (exc) begin
      exccode_d = code;
      // Nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = bus.c0_wb_bd ? bus.c0_wb_pc - 32'd4 : bus.c0_wb_pc;
        bd_d  = bus.c0_wb_bd;
      end
      exl_d = 1'b1;
      if (code == ExcAdel || code == ExcAdes) badvaddr_d = bus.ws_badvaddr;
    end else if (ert) begin
      exl_d = 1'b0;
    end else if (wr) begin
      case (bus.c0_addr)
        RegStatus: begin
          im_d  = bus.c0_wdata[15:8];
          exl_d = bus.c0_wdata[1];
          ie_d  = bus.c0_wdata[0];
        end
        RegCause: ip_sw_d = bus.c0_wdata[9:8];
        RegEpc:   epc_d   = bus.c0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

  // BEV (bit 22) is hard-wired to 1.
  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

  always_comb begin
    case (bus.c0_addr)
      RegBadVAddr: bus.c0_res = badvaddr_q;
      RegCount:    bus.c0_res = count;
      RegCompare:  bus.c0_res = compare;
      RegStatus:   bus.c0_res = status_rd;
      RegCause:    bus.c0_res = cause_rd;
      RegEpc:      bus.c0_res = epc_q;
      default:     bus.c0_res = '0;
    endcase
  end

  assign bus.c0_valid = v & e[ExcBitMfc0];
  assign bus.flush    = exc | ert;
  assign bus.flush_pc = ert ? epc_q : EX_ENTRY;
  assign c0_has_int   = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: inputs change on the falling edge, combinational
// outputs are sampled 1 time unit later, register effects are read back via mfc0.
module tb_cp0_regfile;

  localparam logic [8:0] ERi   = 9'h001;
  localparam logic [8:0] EAdel = 9'h004;
  localparam logic [8:0] EOv   = 9'h008;
  localparam logic [8:0] EEret = 9'h020;
  localparam logic [8:0] EMtc0 = 9'h040;
  localparam logic [8:0] EMfc0 = 9'h080;
  localparam logic [8:0] ESys  = 9'h100;

  localparam logic [4:0] ABad = 5'd8, ACnt = 5'd9, ACmp = 5'd11;
  localparam logic [4:0] ASr = 5'd12, ACause = 5'd13, AEpc = 5'd14;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] ext_int;
  logic       c0_has_int;
  int         checks = 0;
  int         failures = 0;

  cp0_regfile_if bus ();

  cp0_regfile #(
    .EX_ENTRY  (32'hbfc00380),
    .COUNT_DIV (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .ext_int    (ext_int),
    .c0_has_int (c0_has_int)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.c0_wb_valid  = 1'b0;
    bus.c0_exception = '0;
    bus.c0_int       = 1'b0;
    bus.c0_addr      = '0;
    bus.c0_wdata     = '0;
    bus.c0_wb_bd     = 1'b0;
    bus.c0_wb_pc     = '0;
    bus.ws_badvaddr  = '0;
  endtask

  // mfc0 read with no clock edge; the result is the current register value.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.c0_wb_valid  = 1'b1;
    bus.c0_exception = EMfc0;
    bus.c0_addr      = a;
    #1;
    check(tag, bus.c0_res, exp);
    idle();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.c0_wb_valid  = 1'b1;
    bus.c0_exception = EMtc0;
    bus.c0_addr      = a;
    bus.c0_wdata     = d;
    #1;
    check("mtc0_noflush", {31'b0, bus.flush}, 32'd0);
    @(negedge clk);
    idle();
  endtask

  // Exception/eret in WB for one cycle; checks flush and redirect before the commit edge.
  task automatic issue(input string tag, input logic [8:0] ev, input logic intr,
                       input logic [31:0] pc, input logic bd, input logic [31:0] bad,
                       input logic [31:0] exp_pc);
    bus.c0_wb_valid  = 1'b1;
    bus.c0_exception = ev;
    bus.c0_int       = intr;
    bus.c0_wb_pc     = pc;
    bus.c0_wb_bd     = bd;
    bus.ws_badvaddr  = bad;
    bus.c0_addr      = AEpc;
    bus.c0_wdata     = 32'h1111_1111;
    #1;
    check({tag, "_flush"}, {31'b0, bus.flush}, 32'd1);
    check({tag, "_flush_pc"}, bus.flush_pc, exp_pc);
    @(negedge clk);
    idle();
  endtask

  initial begin
    resetn  = 1'b0;
    ext_int = '0;
    idle();
    #1;
    check("reset_flush", {31'b0, bus.flush}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rd("reset_status", ASr, 32'h0040_0000);
    rd("reset_cause", ACause, 32'h0);
    rd("reset_epc", AEpc, 32'h0);

    // Timer interrupt path.
    mtc0(ASr, 32'h0000_8001);
    rd("status_im7_ie", ASr, 32'h0040_8001);
    mtc0(ACmp, 32'd5);
    mtc0(ACnt, 32'd0);
    check("has_int_idle", {31'b0, c0_has_int}, 32'd0);
    rd("cause_no_ti", ACause, 32'h0);
    repeat (9) @(negedge clk);
    rd("count_at_5", ACnt, 32'd5);
    rd("cause_before_ti", ACause, 32'h0);
    @(negedge clk);
    rd("cause_ti_set", ACause, 32'h4000_0000);
    check("has_int_early", {31'b0, c0_has_int}, 32'd0);
    @(negedge clk);
    rd("cause_ip7", ACause, 32'h4000_8000);
    check("has_int_timer", {31'b0, c0_has_int}, 32'd1);
    mtc0(ACmp, 32'h100);
    rd("cause_ti_clear", ACause, 32'h0000_8000);
    mtc0(ASr, 32'h0);
    check("has_int_masked", {31'b0, c0_has_int}, 32'd0);

    // Overflow in a delay slot.
    issue("ov", EOv, 1'b0, 32'hbfc0_0100, 1'b1, 32'h0, 32'hbfc0_0380);
    rd("ov_epc", AEpc, 32'hbfc0_00fc);
    rd("ov_cause", ACause, 32'h8000_0030);
    rd("ov_status", ASr, 32'h0040_0002);

    // eret returns to EPC and clears EXL.
    mtc0(AEpc, 32'hbfc0_0200);
    issue("eret1", EEret, 1'b0, 32'h0, 1'b0, 32'h0, 32'hbfc0_0200);
    rd("eret1_status", ASr, 32'h0040_0000);
    rd("eret1_epc", AEpc, 32'hbfc0_0200);

    // adel beats ri and captures BadVAddr.
    issue("adel", EAdel | ERi, 1'b0, 32'hbfc0_0300, 1'b0, 32'h3, 32'hbfc0_0380);
    rd("adel_cause", ACause, 32'h0000_0010);
    rd("adel_bad", ABad, 32'h3);
    rd("adel_epc", AEpc, 32'hbfc0_0300);

    // Nested ri under EXL: EPC/BD/BadVAddr untouched.
    issue("ri", ERi, 1'b0, 32'h0000_1234, 1'b1, 32'hdead, 32'hbfc0_0380);
    rd("ri_cause", ACause, 32'h0000_0028);
    rd("ri_bad", ABad, 32'h3);
    rd("ri_epc", AEpc, 32'hbfc0_0300);
    issue("eret2", EEret, 1'b0, 32'h0, 1'b0, 32'h0, 32'hbfc0_0300);

    // Count wrap within COUNT_DIV cycles.
    mtc0(ACnt, 32'hffff_ffff);
    rd("count_load", ACnt, 32'hffff_ffff);
    repeat (2) @(negedge clk);
    rd("count_wrap", ACnt, 32'h0);

    // mtc0 together with sys: the write is suppressed.
    issue("sys", ESys | EMtc0, 1'b0, 32'hbfc0_0400, 1'b0, 32'h0, 32'hbfc0_0380);
    rd("sys_epc", AEpc, 32'hbfc0_0400);
    rd("sys_cause", ACause, 32'h0000_0020);
    rd("sys_status", ASr, 32'h0040_0002);
    issue("eret3", EEret, 1'b0, 32'h0, 1'b0, 32'h0, 32'hbfc0_0400);

    // Hardware and software interrupt pending bits.
    ext_int = 6'b000011;
    mtc0(ACause, 32'hffff_ffff);
    rd("cause_ip", ACause, 32'h0000_0f20);

    // Interrupt tag has top priority.
    issue("int", EOv, 1'b1, 32'h0000_0400, 1'b0, 32'h7, 32'hbfc0_0380);
    rd("int_cause", ACause, 32'h0000_0f00);
    rd("int_epc", AEpc, 32'h0000_0400);
    rd("int_bad", ABad, 32'h3);

    rd("unmapped", 5'd3, 32'h0);
    bus.c0_exception = EMfc0;
    #1;
    check("c0_valid_lo", {31'b0, bus.c0_valid}, 32'd0);
    bus.c0_wb_valid = 1'b1;
    #1;
    check("c0_valid_hi", {31'b0, bus.c0_valid}, 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
